// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller for an external 2^ADDR_W-entry store; status is combinational from registered pointers, errors registered.
// No backpressure: writes while full and reads while empty are dropped and flagged; FIFO_CTRL_ERR_STICKY_EN makes error flags sticky.
module fifo_ctrl #(
    parameter int ADDR_W    = 4,
    parameter int THRESHOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic              rd,
    input  logic              clr_err,
    output logic              fifo_we,
    output logic              fifo_rd,
    output logic [ADDR_W:0]   wptr,
    output logic [ADDR_W:0]   rptr,
    output logic [ADDR_W:0]   fill_level,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              fifo_threshold,
    output logic              fifo_overflow,
    output logic              fifo_underflow
);

    localparam logic [ADDR_W:0] THR_LVL = (ADDR_W + 1)'(THRESHOLD);
    localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

    logic ovf_evt;
    logic unf_evt;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign fifo_empty     = (wptr == rptr);
    assign fifo_full      = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                            (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
    assign fill_level     = wptr - rptr;
    assign fifo_threshold = (fill_level >= THR_LVL);

    assign fifo_we = wr & ~fifo_full;
    assign fifo_rd = rd & ~fifo_empty;
    assign ovf_evt = wr & fifo_full;
    assign unf_evt = rd & fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (fifo_we) wptr <= wptr + PTR_INC;
            if (fifo_rd) rptr <= rptr + PTR_INC;
        end
    end

`ifdef FIFO_CTRL_ERR_STICKY_EN
    // A new event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            if (ovf_evt)      fifo_overflow <= 1'b1;
            else if (clr_err) fifo_overflow <= 1'b0;
            if (unf_evt)      fifo_underflow <= 1'b1;
            else if (clr_err) fifo_underflow <= 1'b0;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_overflow  <= 1'b0;
            fifo_underflow <= 1'b0;
        end else begin
            fifo_overflow  <= ovf_evt;
            fifo_underflow <= unf_evt;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized scoreboard bench for fifo_ctrl against a queue-based FIFO model.
module tb_fifo_ctrl;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int THR   = 8;
    localparam int PMOD  = 32;

    typedef struct {
        logic we, rd, full, empty, thr, ovf, unf;
        int   wptr, rptr, fill, head;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic          fifo_we, fifo_rd, fifo_full, fifo_empty, fifo_threshold;
    logic          fifo_overflow, fifo_underflow;
    logic [AW:0]   wptr, rptr, fill_level;
    logic [7:0]    din = 8'h00;
    logic [7:0]    mem [DEPTH];

    exp_t sb[$];
    int   mq[$];
    int   m_wcnt = 0, m_rcnt = 0;
    logic m_ovf = 1'b0, m_unf = 1'b0;
    int   vectors = 0, errs = 0;

    fifo_ctrl #(.ADDR_W(AW), .THRESHOLD(THR)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd), .clr_err(clr_err),
        .fifo_we(fifo_we), .fifo_rd(fifo_rd), .wptr(wptr), .rptr(rptr),
        .fill_level(fill_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_threshold(fifo_threshold), .fifo_overflow(fifo_overflow),
        .fifo_underflow(fifo_underflow)
    );

    always #5 clk = ~clk;

    // Bench-side storage array addressed by the DUT's pointers.
    always @(posedge clk) if (fifo_we) mem[wptr[AW-1:0]] <= din;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic c);
        exp_t e;
        logic ovf_ev, unf_ev;
        @(negedge clk);
        wr = w; rd = r; clr_err = c; din = 8'($urandom);
        e.full  = (mq.size() == DEPTH);
        e.empty = (mq.size() == 0);
        e.we    = w && !e.full;
        e.rd    = r && !e.empty;
        e.wptr  = m_wcnt % PMOD;
        e.rptr  = m_rcnt % PMOD;
        e.fill  = mq.size();
        e.thr   = (mq.size() >= THR);
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        e.head  = e.empty ? 0 : mq[0];
        sb.push_back(e);
        ovf_ev = w && e.full;
        unf_ev = r && e.empty;
        if (e.rd) void'(mq.pop_front());
        if (e.we) mq.push_back(int'(din));
        m_wcnt += int'(e.we);
        m_rcnt += int'(e.rd);
`ifdef FIFO_CTRL_ERR_STICKY_EN
        m_ovf = ovf_ev ? 1'b1 : (c ? 1'b0 : m_ovf);
        m_unf = unf_ev ? 1'b1 : (c ? 1'b0 : m_unf);
`else
        m_ovf = ovf_ev;
        m_unf = unf_ev;
`endif
    endtask

    // Reset pulse entirely between two rising edges; outputs checked while rst_n is low.
    task automatic reset_pulse();
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0; wr = 1'b0; rd = 1'b0; clr_err = 1'b0;
        mq.delete();
        m_wcnt = 0; m_rcnt = 0; m_ovf = 1'b0; m_unf = 1'b0;
        e.we = 1'b0; e.rd = 1'b0; e.full = 1'b0; e.empty = 1'b1; e.thr = 1'b0;
        e.ovf = 1'b0; e.unf = 1'b0; e.wptr = 0; e.rptr = 0; e.fill = 0; e.head = 0;
        sb.push_back(e);
        #3 rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("fifo_we",        int'(fifo_we),        int'(e.we));
                check("fifo_rd",        int'(fifo_rd),        int'(e.rd));
                check("wptr",           int'(wptr),           e.wptr);
                check("rptr",           int'(rptr),           e.rptr);
                check("fill_level",     int'(fill_level),     e.fill);
                check("fifo_full",      int'(fifo_full),      int'(e.full));
                check("fifo_empty",     int'(fifo_empty),     int'(e.empty));
                check("fifo_threshold", int'(fifo_threshold), int'(e.thr));
                check("fifo_overflow",  int'(fifo_overflow),  int'(e.ovf));
                check("fifo_underflow", int'(fifo_underflow), int'(e.unf));
                if (e.rd) check("head_data", int'(mem[rptr[AW-1:0]]), e.head);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks pending", sb.size());
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int pw, pr;
        rst_n = 1'b0;
        reset_pulse();
        repeat (16) step(1'b1, 1'b0, 1'b0);          // fill to full
        step(1'b1, 1'b0, 1'b0);                      // overflow attempt
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);                      // clear errors
        step(1'b0, 1'b0, 1'b0);
        repeat (16) step(1'b0, 1'b1, 1'b0);          // drain
        step(1'b0, 1'b1, 1'b0);                      // underflow attempt
        step(1'b1, 1'b1, 1'b0);                      // wr+rd while empty
        step(1'b0, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b0, 1'b0);           // now 5 entries
        repeat (40) step(1'b1, 1'b1, 1'b0);          // steady state across pointer wrap
        repeat (11) step(1'b1, 1'b0, 1'b0);          // full again
        step(1'b1, 1'b1, 1'b0);                      // wr+rd while full
        repeat (2) step(1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b1, 1'b0);           // 10 entries
        reset_pulse();
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        for (int blk = 0; blk < 8; blk++) begin
            pw = $urandom_range(10, 90);
            pr = $urandom_range(10, 90);
            for (int i = 0; i < 100; i++) begin
                if ($urandom_range(0, 299) == 0) reset_pulse();
                step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr,
                     $urandom_range(0, 15) == 0);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 10 && sb.size() != 0; t++) @(negedge clk);
        #2;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: storage address width; the storage holds 2^ADDR_W entries and pointers are ADDR_W+1 bits wide.
REQ-002 Parameter THRESHOLD, default 8: fill level at or above which fifo_threshold asserts; legal range 1..2^ADDR_W.
REQ-003 Port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-005 Port wr, input, 1: write request from the producer.
REQ-006 Port rd, input, 1: read request from the consumer.
REQ-007 Port clr_err, input, 1: clears the overflow and underflow flags.
REQ-008 Port fifo_we, output, 1: write enable to the storage array.
REQ-009 Port fifo_rd, output, 1: read accepted this cycle.
REQ-010 Port wptr, output, ADDR_W+1: write pointer to storage; the MSB is the wrap bit.
REQ-011 Port rptr, output, ADDR_W+1: read pointer to storage; the MSB is the wrap bit.
REQ-012 Port fill_level, output, ADDR_W+1: number of occupied entries, 0..2^ADDR_W.
REQ-013 Ports fifo_full, fifo_empty, fifo_threshold, output, 1 each: status flags.
REQ-014 Ports fifo_overflow, fifo_underflow, output, 1 each: error flags.

Function
REQ-015 fifo_we SHALL be combinational, equal to wr AND NOT fifo_full.
REQ-016 fifo_rd SHALL be combinational, equal to rd AND NOT fifo_empty.
REQ-017 wptr SHALL increment by 1, modulo 2^(ADDR_W+1), on each clock edge where fifo_we=1; otherwise it SHALL hold.
REQ-018 rptr SHALL increment by 1, modulo 2^(ADDR_W+1), on each clock edge where fifo_rd=1; otherwise it SHALL hold.
REQ-019 Head data SHALL be valid at the storage output in the same cycle that fifo_empty=0, so reads have zero latency.
REQ-020 fill_level SHALL equal (wptr - rptr) mod 2^(ADDR_W+1), derived only from the registered pointers.
REQ-021 fifo_empty SHALL be 1 if and only if wptr equals rptr.
REQ-022 fifo_full SHALL be 1 if and only if the pointer MSBs differ and the lower ADDR_W bits are equal.
REQ-023 fifo_threshold SHALL be 1 if and only if fill_level >= THRESHOLD.
REQ-024 Simultaneous wr and rd when neither full nor empty: both SHALL be accepted and fill_level SHALL be unchanged.
REQ-025 Simultaneous wr and rd while full: only the read SHALL be accepted, and the write SHALL count as an overflow.
REQ-026 Simultaneous wr and rd while empty: only the write SHALL be accepted, and the read SHALL count as an underflow.
REQ-027 An overflow event is wr=1 while fifo_full=1; an underflow event is rd=1 while fifo_empty=1.
REQ-028 Pointer wrap from 2^(ADDR_W+1)-1 to 0 SHALL be seamless, with no flag glitch on any registered output.

Reset
REQ-029 rst_n=0 SHALL immediately force wptr=0, rptr=0 and fifo_overflow=fifo_underflow=0, independent of clk.
REQ-030 During reset the derived outputs SHALL read fifo_empty=1, fifo_full=0, fill_level=0 and fifo_threshold=0.
REQ-031 Reset asserted mid-operation SHALL discard all contents; the first accepted write after release SHALL go to address 0.

Configuration
REQ-032 With macro FIFO_CTRL_ERR_STICKY_EN defined, each error flag SHALL set on its event and hold until a clock edge with clr_err=1 or until reset.
REQ-033 With FIFO_CTRL_ERR_STICKY_EN defined, an event coinciding with clr_err=1 SHALL win, leaving the flag set.
REQ-034 With FIFO_CTRL_ERR_STICKY_EN undefined, each error flag SHALL be a registered one-cycle pulse asserted in the cycle after its event, and clr_err SHALL be ignored.

Verification
REQ-035 Reset, then 16 writes with rd=0 -> wptr=16, fill_level=16, fifo_full=1; fifo_threshold=1 from the 8th write onward.
REQ-036 From full, wr=1 for one cycle -> wptr stays 16, fifo_we=0, fifo_overflow=1 (sticky build: holds until clr_err).
REQ-037 From empty, rd=1 for one cycle -> rptr stays 0, fifo_rd=0, fifo_underflow=1.
REQ-038 With 5 entries, wr=rd=1 for 40 cycles -> fill_level stays 5 throughout, and both pointers wrap past 31 to 0 with no glitch on fifo_full or fifo_empty.
REQ-039 While full, wr=rd=1 -> rptr increments, wptr holds, fill_level becomes 15, fifo_overflow=1.
REQ-040 With 10 entries, pulse rst_n low between clock edges -> pointers are 0 and fifo_empty=1 before the next edge; the next write lands at address 0.
